// File: rtl/adc_pkg.sv
// Shared definitions for the multi-channel serial ADC capture block:
// FSM state encoding and the counter-width helper.
package adc_pkg;

   // Capture sequencer states
   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      CONVERT = 3'd1,
      SCK_HI  = 3'd2,
      SCK_LO  = 3'd3,
      DONE    = 3'd4
   } adc_state_e;

   // Ceiling log2, used to size counters from elaboration-time constants
   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/adc_shift_rx.sv
// Per-channel serial receiver: MSB-first shift register loaded one bit per
// SCK pulse. Older (lead) bits fall off the top once the register is full.
module adc_shift_rx #(
   parameter int W = 12
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic         shift_en,
   input  logic         sdo,
   output logic [W-1:0] pdata
);

   logic [W-1:0] shreg_q, shreg_d;

   // Next shift-register contents: shift left, new bit enters at the LSB
   always_comb begin
      shreg_d = shreg_q;
      if (shift_en) shreg_d = (shreg_q << 1) | W'(sdo);
   end

   // Shift-register storage
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) shreg_q <= '0;
      else       shreg_q <= shreg_d;
   end

   assign pdata = shreg_q;

endmodule

// File: rtl/adc_capture_multi.sv
// Multi-channel laser-pulse ADC capture. One CNV/SCK pair is shared by
// NUM_CH serial ADCs; all SDO lines are shifted in lock-step.
// Optional feature macro: ADC_PEAK_HOLD_EN enables per-channel peak hold.
// Without it peak_data is tied to zero and clear_peak has no effect.
//
// Handshake: sample_valid is a one-cycle strobe with no back-pressure; the
// cycle it is high, sample_data already holds the new words and stays
// stable until the next strobe. busy covers trigger edge to sample_valid.
module adc_capture_multi
   import adc_pkg::*;
#(
   parameter int NUM_CH    = 2,
   parameter int DATA_W    = 12,
   parameter int LEAD_BITS = 2,
   parameter int OUT_W     = 16,
   parameter int CONV_CYC  = 22,
   parameter int SCK_DIV   = 1
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic                    trigger,
   input  logic                    clear_peak,
   input  logic [NUM_CH-1:0]       adc_sdo,
   output logic                    adc_convert,
   output logic                    adc_sck,
   output logic                    busy,
   output logic                    sample_valid,
   output logic [NUM_CH*OUT_W-1:0] sample_data,
   output logic                    overrun,
   output logic [NUM_CH*OUT_W-1:0] peak_data
);

   localparam int NBITS   = LEAD_BITS + DATA_W;
   localparam int BIT_W   = clog2(NBITS + 1);
   localparam int CYC_MAX = (CONV_CYC > SCK_DIV) ? CONV_CYC : SCK_DIV;
   localparam int CYC_W   = clog2(CYC_MAX + 1);

   localparam logic [CYC_W-1:0] CONV_LAST = CYC_W'(CONV_CYC - 1);
   localparam logic [CYC_W-1:0] SCK_LAST  = CYC_W'(SCK_DIV - 1);
   localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(NBITS - 1);

   adc_state_e               state_q, state_d;
   logic [CYC_W-1:0]         cyc_cnt_q, cyc_cnt_d;
   logic [BIT_W-1:0]         bit_cnt_q, bit_cnt_d;
   logic                     trigger_dly_q, trigger_dly_d;
   logic                     adc_convert_q, adc_convert_d;
   logic                     adc_sck_q, adc_sck_d;
   logic                     busy_q, busy_d;
   logic                     sample_valid_q, sample_valid_d;
   logic                     overrun_q, overrun_d;
   logic [NUM_CH*OUT_W-1:0]  sample_data_q, sample_data_d;

   logic                     trig_edge;
   logic                     shift_en;
   logic [DATA_W-1:0]        rx_data [NUM_CH];
   logic [NUM_CH*OUT_W-1:0]  rx_packed;

   assign trig_edge = trigger & ~trigger_dly_q;

   // One receiver per channel, all clocked by the same shift strobe
   for (genvar k = 0; k < NUM_CH; k++) begin : g_rx
      adc_shift_rx #(.W(DATA_W)) u_rx (
         .clk      (clk),
         .rstn     (rstn),
         .shift_en (shift_en),
         .sdo      (adc_sdo[k]),
         .pdata    (rx_data[k])
      );
   end

   // Zero-extend each channel's received word into the output layout
   always_comb begin
      rx_packed = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         rx_packed[k*OUT_W +: OUT_W] = OUT_W'(rx_data[k]);
      end
   end

   // Sequencer next-state and registered-output logic. The result is
   // published on the transition into DONE so the strobe lands exactly
   // one conversion-plus-readout after the trigger edge.
   always_comb begin
      state_d        = state_q;
      cyc_cnt_d      = cyc_cnt_q;
      bit_cnt_d      = bit_cnt_q;
      trigger_dly_d  = trigger;
      adc_convert_d  = adc_convert_q;
      busy_d         = busy_q;
      sample_valid_d = 1'b0;
      sample_data_d  = sample_data_q;
      overrun_d      = trig_edge && (state_q != IDLE);
      shift_en       = 1'b0;

      case (state_q)
         IDLE: begin
            adc_convert_d = 1'b1;
            busy_d        = 1'b0;
            if (trig_edge) begin
               adc_convert_d = 1'b0;
               busy_d        = 1'b1;
               cyc_cnt_d     = '0;
               bit_cnt_d     = '0;
               state_d       = CONVERT;
            end
         end
         CONVERT: begin
            if (cyc_cnt_q == CONV_LAST) begin
               cyc_cnt_d = '0;
               state_d   = SCK_HI;
            end else begin
               cyc_cnt_d = cyc_cnt_q + CYC_W'(1);
            end
         end
         SCK_HI: begin
            if (cyc_cnt_q == SCK_LAST) begin
               cyc_cnt_d = '0;
               shift_en  = 1'b1;
               state_d   = SCK_LO;
            end else begin
               cyc_cnt_d = cyc_cnt_q + CYC_W'(1);
            end
         end
         SCK_LO: begin
            if (cyc_cnt_q == SCK_LAST) begin
               cyc_cnt_d = '0;
               bit_cnt_d = bit_cnt_q + BIT_W'(1);
               if (bit_cnt_q == BIT_LAST) begin
                  state_d        = DONE;
                  sample_valid_d = 1'b1;
                  sample_data_d  = rx_packed;
                  busy_d         = 1'b0;
                  adc_convert_d  = 1'b1;
               end else begin
                  state_d = SCK_HI;
               end
            end else begin
               cyc_cnt_d = cyc_cnt_q + CYC_W'(1);
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      adc_sck_d = (state_d == SCK_HI);
   end

   // Sequencer and output registers
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q        <= IDLE;
         cyc_cnt_q      <= '0;
         bit_cnt_q      <= '0;
         trigger_dly_q  <= 1'b0;
         adc_convert_q  <= 1'b0;
         adc_sck_q      <= 1'b0;
         busy_q         <= 1'b0;
         sample_valid_q <= 1'b0;
         overrun_q      <= 1'b0;
         sample_data_q  <= '0;
      end else begin
         state_q        <= state_d;
         cyc_cnt_q      <= cyc_cnt_d;
         bit_cnt_q      <= bit_cnt_d;
         trigger_dly_q  <= trigger_dly_d;
         adc_convert_q  <= adc_convert_d;
         adc_sck_q      <= adc_sck_d;
         busy_q         <= busy_d;
         sample_valid_q <= sample_valid_d;
         overrun_q      <= overrun_d;
         sample_data_q  <= sample_data_d;
      end
   end

   assign adc_convert  = adc_convert_q;
   assign adc_sck      = adc_sck_q;
   assign busy         = busy_q;
   assign sample_valid = sample_valid_q;
   assign sample_data  = sample_data_q;
   assign overrun      = overrun_q;

`ifdef ADC_PEAK_HOLD_EN
   logic [NUM_CH*OUT_W-1:0] peak_q, peak_d;

   // Running unsigned maximum per channel; a clear coinciding with a new
   // sample restarts the maximum from that sample
   always_comb begin
      peak_d = peak_q;
      for (int k = 0; k < NUM_CH; k++) begin
         if (clear_peak) begin
            peak_d[k*OUT_W +: OUT_W] = sample_valid_q ? sample_data_q[k*OUT_W +: OUT_W]
                                                      : '0;
         end else if (sample_valid_q &&
                      (sample_data_q[k*OUT_W +: OUT_W] > peak_q[k*OUT_W +: OUT_W])) begin
            peak_d[k*OUT_W +: OUT_W] = sample_data_q[k*OUT_W +: OUT_W];
         end
      end
   end

   // Peak storage
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) peak_q <= '0;
      else       peak_q <= peak_d;
   end

   assign peak_data = peak_q;
`else
   logic unused_clear_peak;
   assign unused_clear_peak = clear_peak;
   assign peak_data         = '0;
`endif

endmodule

// File: tb/tb_adc_capture_multi.sv
// Bench for adc_capture_multi: default 2-channel instance plus a 4-channel,
// 16-bit, SCK_DIV=3, no-lead-bit instance. ADC models shift a preset word
// MSB first, updating SDO on each SCK falling edge.
module tb_adc_capture_multi;

`ifdef ADC_PEAK_HOLD_EN
   localparam bit PEAK_EN = 1'b1;
`else
   localparam bit PEAK_EN = 1'b0;
`endif

   localparam int LAT2 = 1 + 22 + 2 * 1 * (2 + 12);
   localparam int LAT4 = 1 + 22 + 2 * 3 * (0 + 16);

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rstn;
   logic        trigger, clear_peak;
   logic [1:0]  adc_sdo;
   logic        adc_convert, adc_sck, busy, sample_valid, overrun;
   logic [31:0] sample_data, peak_data;

   logic        trigger4, clear_peak4;
   logic [3:0]  adc_sdo4;
   logic        adc_convert4, adc_sck4, busy4, sample_valid4, overrun4;
   logic [63:0] sample_data4, peak_data4;

   adc_capture_multi dut (
      .clk(clk), .rstn(rstn), .trigger(trigger), .clear_peak(clear_peak),
      .adc_sdo(adc_sdo), .adc_convert(adc_convert), .adc_sck(adc_sck),
      .busy(busy), .sample_valid(sample_valid), .sample_data(sample_data),
      .overrun(overrun), .peak_data(peak_data)
   );

   adc_capture_multi #(
      .NUM_CH(4), .DATA_W(16), .LEAD_BITS(0), .OUT_W(16), .CONV_CYC(22), .SCK_DIV(3)
   ) dut4 (
      .clk(clk), .rstn(rstn), .trigger(trigger4), .clear_peak(clear_peak4),
      .adc_sdo(adc_sdo4), .adc_convert(adc_convert4), .adc_sck(adc_sck4),
      .busy(busy4), .sample_valid(sample_valid4), .sample_data(sample_data4),
      .overrun(overrun4), .peak_data(peak_data4)
   );

   // ---------------- ADC models ----------------
   logic [13:0] frame [2];
   int          bit_i = 0;
   always @(negedge adc_convert) bit_i = 0;
   always @(negedge adc_sck)     bit_i = bit_i + 1;
   always_comb begin
      for (int k = 0; k < 2; k++) adc_sdo[k] = (bit_i < 14) ? frame[k][13 - bit_i] : 1'b0;
   end

   logic [15:0] frame4 [4];
   int          bit4_i = 0;
   always @(negedge adc_convert4) bit4_i = 0;
   always @(negedge adc_sck4)     bit4_i = bit4_i + 1;
   always_comb begin
      for (int k = 0; k < 4; k++) adc_sdo4[k] = (bit4_i < 16) ? frame4[k][15 - bit4_i] : 1'b0;
   end

   // ---------------- monitors ----------------
   int sck_edges = 0, sck4_edges = 0, sck4_hi = 0;
   int ovr_cnt = 0, valid_cnt = 0;
   always @(posedge adc_sck)  sck_edges++;
   always @(posedge adc_sck4) sck4_edges++;
   always @(negedge clk) begin
      if (overrun)      ovr_cnt++;
      if (sample_valid) valid_cnt++;
      if (adc_sck4)     sck4_hi++;
   end

   // ---------------- scoreboard ----------------
   int pass_cnt = 0, total_cnt = 0;
   logic [31:0] exp_q [$];
   logic [11:0] pk [2];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Reference peak model: unsigned running max, clear restarts from sample
   task automatic model_peak(input logic [11:0] w0, input logic [11:0] w1, input bit clr);
      if (PEAK_EN) begin
         if (clr) begin
            pk[0] = w0; pk[1] = w1;
         end else begin
            if (w0 > pk[0]) pk[0] = w0;
            if (w1 > pk[1]) pk[1] = w1;
         end
      end
   endtask

   function automatic logic [31:0] exp_peak();
      return {4'h0, pk[1], 4'h0, pk[0]};
   endfunction

   // ---------------- drivers ----------------
   // mode: 0 normal, 1 clear_peak with sample_valid, 2 trigger edge in DONE,
   //       3 trigger held high for the whole capture
   task automatic capture(input logic [11:0] w0, input logic [11:0] w1, input int mode,
                          input int retrig_at, output int lat, output int conv_low,
                          output logic [31:0] data);
      frame[0] = {2'b00, w0};
      frame[1] = {2'b00, w1};
      sck_edges = 0; conv_low = 0; lat = 0; data = '0;
      @(negedge clk) trigger = 1'b1;
      for (int n = 1; n <= 200; n++) begin
         @(negedge clk);
         if (!adc_convert) conv_low++;
         if (n == 10) check("busy_mid", {63'd0, busy}, 64'd1);
         if (sample_valid) begin
            lat  = n;
            data = sample_data;
            if (mode == 1) clear_peak = 1'b1;
            if (mode == 2) trigger = 1'b1;
            break;
         end
         if (n == 2 && mode != 3) trigger = 1'b0;
         if (retrig_at != 0 && n == retrig_at)     trigger = 1'b1;
         if (retrig_at != 0 && n == retrig_at + 2) trigger = 1'b0;
      end
      @(negedge clk);
      clear_peak = 1'b0;
      if (mode != 3) trigger = 1'b0;
   endtask

   task automatic capture4(input logic [63:0] words, output int lat, output logic [63:0] data);
      for (int k = 0; k < 4; k++) frame4[k] = words[k*16 +: 16];
      sck4_edges = 0; sck4_hi = 0; lat = 0; data = '0;
      @(negedge clk) trigger4 = 1'b1;
      for (int n = 1; n <= 300; n++) begin
         @(negedge clk);
         if (n == 2) trigger4 = 1'b0;
         if (sample_valid4) begin
            lat = n; data = sample_data4;
            break;
         end
      end
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic [11:0] w0;
      logic [11:0] w1;
      int          mode;
      int          retrig;
      logic [31:0] exp_data;
      int          exp_lat;
      int          exp_conv_low;
      int          exp_sck;
      int          exp_ovr;
   } vec_t;

   vec_t vecs [8];

   task automatic set_vec(input int i, input logic [11:0] w0, input logic [11:0] w1,
                          input int mode, input int retrig);
      vecs[i].w0           = w0;
      vecs[i].w1           = w1;
      vecs[i].mode         = mode;
      vecs[i].retrig       = retrig;
      vecs[i].exp_data     = {4'h0, w1, 4'h0, w0};
      vecs[i].exp_lat      = LAT2;
      vecs[i].exp_conv_low = LAT2 - 1;
      vecs[i].exp_sck      = 14;
      vecs[i].exp_ovr      = (retrig != 0) ? 1 : 0;
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int          lat, conv_low, v0, o0;
      logic [31:0] data;
      logic [63:0] data4, w4;
      logic [11:0] r0, r1;

      rstn = 1'b0; trigger = 1'b0; clear_peak = 1'b0;
      trigger4 = 1'b0; clear_peak4 = 1'b0;
      frame[0] = '0; frame[1] = '0;
      for (int k = 0; k < 4; k++) frame4[k] = '0;
      pk[0] = '0; pk[1] = '0;

      set_vec(0, 12'hABC, 12'h123, 0, 0);
      set_vec(1, 12'hABC, 12'h123, 0, 20);
      set_vec(2, 12'h100, 12'h010, 0, 0);
      set_vec(3, 12'h0FF, 12'h020, 0, 0);
      set_vec(4, 12'h200, 12'h001, 0, 0);
      set_vec(5, 12'h050, 12'h000, 1, 0);
      set_vec(6, 12'hFFF, 12'hFFF, 0, 0);
      set_vec(7, 12'h000, 12'h800, 0, 0);

      // Reset state
      #1;
      check("rst_convert", {63'd0, adc_convert}, 64'd0);
      check("rst_outputs", {58'd0, adc_sck, busy, sample_valid, overrun, 2'b00}, 64'd0);
      check("rst_data", {32'd0, sample_data}, 64'd0);
      idle(2);
      rstn = 1'b1;
      @(negedge clk);
      check("rel_convert", {63'd0, adc_convert}, 64'd1);
      check("rel_sck", {63'd0, adc_sck}, 64'd0);
      idle(2);

      // Table-driven captures
      for (int i = 0; i < 8; i++) begin
         o0 = ovr_cnt;
         capture(vecs[i].w0, vecs[i].w1, vecs[i].mode, vecs[i].retrig, lat, conv_low, data);
         model_peak(vecs[i].w0, vecs[i].w1, vecs[i].mode == 1);
         check($sformatf("v%0d_data", i), {32'd0, data}, {32'd0, vecs[i].exp_data});
         check($sformatf("v%0d_lat", i), lat, vecs[i].exp_lat);
         check($sformatf("v%0d_conv_low", i), conv_low, vecs[i].exp_conv_low);
         check($sformatf("v%0d_sck", i), sck_edges, vecs[i].exp_sck);
         check($sformatf("v%0d_ovr", i), ovr_cnt - o0, vecs[i].exp_ovr);
         check($sformatf("v%0d_busy_end", i), {63'd0, busy}, 64'd0);
         check($sformatf("v%0d_peak", i), {32'd0, peak_data}, {32'd0, exp_peak()});
         idle(3);
      end

      // Standalone clear_peak: peak to zero, sample_data untouched
      @(negedge clk) clear_peak = 1'b1;
      @(negedge clk) clear_peak = 1'b0;
      if (PEAK_EN) begin pk[0] = '0; pk[1] = '0; end
      check("clr_peak", {32'd0, peak_data}, {32'd0, exp_peak()});
      check("clr_keeps_data", {32'd0, sample_data}, {32'd0, vecs[7].exp_data});
      idle(2);

      // Randomized captures against the scoreboard
      for (int i = 0; i < 10; i++) begin
         r0 = 12'($urandom_range(0, 4095));
         r1 = 12'($urandom_range(0, 4095));
         exp_q.push_back({4'h0, r1, 4'h0, r0});
         capture(r0, r1, 0, 0, lat, conv_low, data);
         model_peak(r0, r1, 1'b0);
         check("rnd_data", {32'd0, data}, {32'd0, exp_q.pop_front()});
         check("rnd_lat", lat, LAT2);
         check("rnd_peak", {32'd0, peak_data}, {32'd0, exp_peak()});
         idle($urandom_range(1, 4));
      end

      // Trigger edge during DONE: lost, counted as overrun, no new capture
      o0 = ovr_cnt;
      capture(12'h5A5, 12'hA5A, 2, 0, lat, conv_low, data);
      model_peak(12'h5A5, 12'hA5A, 1'b0);
      v0 = valid_cnt;
      idle(70);
      check("done_trig_ovr", ovr_cnt - o0, 1);
      check("done_trig_no_capture", valid_cnt - v0, 0);
      check("done_trig_idle", {62'd0, busy, adc_convert}, 64'd1);

      // Trigger held high: single capture only
      o0 = ovr_cnt;
      capture(12'h321, 12'h654, 3, 0, lat, conv_low, data);
      model_peak(12'h321, 12'h654, 1'b0);
      check("hold_data", {32'd0, data}, {32'd0, 4'h0, 12'h654, 4'h0, 12'h321});
      v0 = valid_cnt;
      idle(70);
      check("hold_no_retrig", valid_cnt - v0, 0);
      check("hold_ovr", ovr_cnt - o0, 0);
      trigger = 1'b0;
      idle(2);

      // Reset in the middle of the SCK phase
      frame[0] = {2'b00, 12'h777}; frame[1] = {2'b00, 12'h888};
      v0 = valid_cnt;
      @(negedge clk) trigger = 1'b1;
      idle(2);
      trigger = 1'b0;
      idle(28);
      rstn = 1'b0;
      #1;
      check("arst_outputs", {58'd0, adc_convert, adc_sck, busy, sample_valid, overrun, 1'b0}, 64'd0);
      check("arst_data", {sample_data, peak_data}, 64'd0);
      pk[0] = '0; pk[1] = '0;
      idle(3);
      rstn = 1'b1;
      @(negedge clk);
      check("arst_rel_convert", {63'd0, adc_convert}, 64'd1);
      idle(60);
      check("arst_no_valid", valid_cnt - v0, 0);
      capture(12'h9C3, 12'h3C9, 0, 0, lat, conv_low, data);
      model_peak(12'h9C3, 12'h3C9, 1'b0);
      check("arst_after_data", {32'd0, data}, {32'd0, 4'h0, 12'h3C9, 4'h0, 12'h9C3});
      check("arst_after_lat", lat, LAT2);
      check("arst_after_peak", {32'd0, peak_data}, {32'd0, exp_peak()});
      idle(3);

      // Four-channel, 16-bit, slow SCK instance
      for (int i = 0; i < 3; i++) begin
         if (i == 0)      w4 = {16'h7FFE, 16'h8001, 16'h0000, 16'hFFFF};
         else if (i == 1) w4 = {16'hFFFF, 16'h7FFE, 16'h8001, 16'h0000};
         else             w4 = {$urandom, $urandom};
         capture4(w4, lat, data4);
         check($sformatf("c4_%0d_data", i), data4, w4);
         check($sformatf("c4_%0d_lat", i), lat, LAT4);
         check($sformatf("c4_%0d_sck", i), sck4_edges, 16);
         check($sformatf("c4_%0d_sck_hi", i), sck4_hi, 48);
         idle(3);
      end

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   // Global time bound
   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish, got running expected finished");
      $fatal(1);
   end

endmodule
